// File: rtl/bitserial_subtractor.sv
// Bit-serial subtractor: D = (S - A) mod 2^WIDTH, computed LSB first with a
// single full-subtractor cell and a borrow flop. Start/busy/done handshake.
module bitserial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] addend_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ser_bit,
  output logic             ser_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_areg;
  logic [WIDTH-1:0] r_dreg;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_a, w_b, w_d, w_bnext, w_last, w_shift;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  always_comb begin
    w_a     = r_sreg[0];
    w_b     = r_areg[0];
    w_d     = w_a ^ w_b ^ r_borrow;
    w_bnext = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    w_shift = (r_state == SHIFT);
    w_last  = (r_cnt == CW'(WIDTH - 1));
  end

  // Control FSM and datapath; reset clears everything and wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_areg   <= '0;
      r_dreg   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sreg   <= sum_in;
            r_areg   <= addend_in;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Result fills from the MSB side so the first (LSB) bit ends at bit 0.
          r_dreg   <= {w_d, r_dreg[WIDTH-1:1]};
          r_sreg   <= r_sreg >> 1;
          r_areg   <= r_areg >> 1;
          r_borrow <= w_bnext;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            // Load the visible result on the same edge that raises done.
            r_diff  <= {w_d, r_dreg[WIDTH-1:1]};
            r_bout  <= w_bnext;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Serial tap is combinational while shifting; the rest is registered.
  always_comb begin
    ser_bit    = w_shift & w_d;
    ser_valid  = w_shift;
    busy       = r_busy;
    done       = r_done;
    diff_out   = r_diff;
    borrow_out = r_bout;
  end

endmodule

// File: tb/tb_bitserial_subtractor.sv
// Directed + randomised bench for bitserial_subtractor (WIDTH=8).
module tb_bitserial_subtractor;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] sum_in, addend_in;
  logic       busy, done, borrow_out, ser_bit, ser_valid;
  logic [7:0] diff_out;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] prev_d;
  logic       prev_b;

  bitserial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sum_in(sum_in), .addend_in(addend_in),
    .busy(busy), .done(done), .diff_out(diff_out), .borrow_out(borrow_out),
    .ser_bit(ser_bit), .ser_valid(ser_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete operation with per-bit serial checks and held-result checks.
  task automatic run_op(input logic [7:0] s, input logic [7:0] a,
                        input logic [7:0] exp_d, input logic exp_b);
    start = 1'b1; sum_in = s; addend_in = a;
    tick();
    start = 1'b0;
    sum_in = $urandom_range(0, 255); addend_in = $urandom_range(0, 255);
    for (int i = 0; i < 8; i++) begin
      check("ser_valid", {31'd0, ser_valid}, 32'd1);
      check("ser_bit",   {31'd0, ser_bit},   {31'd0, exp_d[i]});
      check("busy_shift", {31'd0, busy},     32'd1);
      check("no_early_done", {31'd0, done},  32'd0);
      check("diff_held", {24'd0, diff_out},  {24'd0, prev_d});
      check("borrow_held", {31'd0, borrow_out}, {31'd0, prev_b});
      tick();
    end
    check("done",      {31'd0, done},       32'd1);
    check("busy_done", {31'd0, busy},       32'd1);
    check("ser_valid_done", {31'd0, ser_valid}, 32'd0);
    check("diff",      {24'd0, diff_out},   {24'd0, exp_d});
    check("borrow",    {31'd0, borrow_out}, {31'd0, exp_b});
    prev_d = exp_d; prev_b = exp_b;
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_idle",  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, ndone;
    logic [7:0] s, a;
    rst = 1'b1; start = 1'b0; sum_in = '0; addend_in = '0;
    prev_d = '0; prev_b = 1'b0;

    // 1. reset
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy",   {31'd0, busy},       32'd0);
    check("rst_done",   {31'd0, done},       32'd0);
    check("rst_diff",   {24'd0, diff_out},   32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
    check("rst_sv",     {31'd0, ser_valid},  32'd0);

    // 2/3. directed vectors
    run_op(8'd100, 8'd37,  8'd63,  1'b0);
    run_op(8'd37,  8'd100, 8'd193, 1'b1);
    run_op(8'd255, 8'd1,   8'd254, 1'b0);
    run_op(8'd0,   8'd0,   8'd0,   1'b0);
    run_op(8'd0,   8'd255, 8'd1,   1'b1);

    // 4. start while busy is ignored, including during done
    start = 1'b1; sum_in = 8'd100; addend_in = 8'd37;
    tick();                                   // accept edge N
    start = 1'b0; ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin start = 1'b1; sum_in = 8'd1; addend_in = 8'd2; end
      else begin start = 1'b0; end
      tick();
      if (done) ndone++;
    end
    check("busy_done_cnt", ndone, 1);
    check("busy_diff", {24'd0, diff_out},   32'd63);
    check("busy_borrow", {31'd0, borrow_out}, 32'd0);
    start = 1'b1; sum_in = 8'd5; addend_in = 8'd3;  // during DONE: ignored
    tick();
    check("done_start_ignored", {31'd0, busy}, 32'd0);
    sum_in = 8'd9; addend_in = 8'd4;               // accepted next edge
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin tick(); cyc++; end
    check("second_latency", cyc, 8);
    check("second_diff", {24'd0, diff_out}, 32'd5);
    check("second_borrow", {31'd0, borrow_out}, 32'd0);
    tick();
    prev_d = 8'd5; prev_b = 1'b0;

    // 5. reset mid-operation
    start = 1'b1; sum_in = 8'd10; addend_in = 8'd20;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",   {31'd0, busy},       32'd0);
    check("abort_diff",   {24'd0, diff_out},   32'd0);
    check("abort_borrow", {31'd0, borrow_out}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    prev_d = 8'd0; prev_b = 1'b0;
    run_op(8'd200, 8'd55, 8'd145, 1'b0);

    // 6. random operations against (S-A) mod 256, borrow = A>S
    for (int k = 0; k < 500; k++) begin
      s = 8'($urandom_range(0, 255));
      a = 8'($urandom_range(0, 255));
      run_op(s, a, s - a, a > s);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        check("gap_no_done", {31'd0, done}, 32'd0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
